// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single 1-bit add/sub cell and a carry/borrow flop,
// reused over WIDTH clocks, LSB first, behind a start/busy/done handshake.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             cin_bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_diff,
  output logic             cout_bout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
  logic [WIDTH-1:0]   res_q,       res_d;
  logic               sel_q,       sel_d;
  logic               c_q,         c_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   sum_diff_q,  sum_diff_d;
  logic               cout_bout_q, cout_bout_d;

  // One-bit add/sub cell operating on the current LSBs and the carry/borrow flop.
  logic a_bit, b_bit, prop, s_bit, c_next;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a_bit  = a_sh_q[0];
    b_bit  = b_sh_q[0];
    prop   = a_bit ^ b_bit;
    s_bit  = prop ^ c_q;
    c_next = sel_q ? ((~a_bit & b_bit) | (~prop & c_q))
                   : ((a_bit & b_bit) | (c_q & prop));
  end

  // Result bits enter at the MSB so the word is aligned after exactly WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = s_bit;
    end else begin : g_res_wn
      assign res_shift = {s_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every output of this block is given a hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    sel_d       = sel_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    sum_diff_d  = sum_diff_q;
    cout_bout_d = cout_bout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sel_d   = sel;
          c_d     = cin_bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        c_d    = c_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_diff_d  = res_shift;
          cout_bout_d = c_next;
          cnt_d       = '0;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      sel_q       <= 1'b0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_diff_q  <= '0;
      cout_bout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      sel_q       <= sel_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      sum_diff_q  <= sum_diff_d;
      cout_bout_q <= cout_bout_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum_diff  = sum_diff_q;
  assign cout_bout = cout_bout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed corner cases plus randomized
// operations at WIDTH=8, and an exhaustive 1-bit sweep at WIDTH=1.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sel8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, sel1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_sum;
  logic       last_cout;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sel(sel8),
    .cin_bin(cin8), .busy(busy8), .done(done8), .sum_diff(sum8), .cout_bout(cout8)
  );

  serial_add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sel(sel1),
    .cin_bin(cin1), .busy(busy1), .done(done1), .sum_diff(sum1), .cout_bout(cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic, returns {carry/borrow, result}.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                      input logic s, input logic c);
    int unsigned ux, uy, uc;
    logic [7:0]  d;
    ux = x; uy = y; uc = c;
    if (!s) return 9'(ux + uy + uc);
    d = 8'(ux - uy - uc);
    return {(ux < uy + uc), d};
  endfunction

  function automatic logic [1:0] ref1(input logic x, input logic y,
                                      input logic s, input logic c);
    int unsigned ux, uy, uc;
    ux = x; uy = y; uc = c;
    if (!s) return 2'(ux + uy + uc);
    return {(ux < uy + uc), 1'(ux - uy - uc)};
  endfunction

  task automatic scramble8();
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    sel8 = 1'($urandom);
    cin8 = 1'($urandom);
  endtask

  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c);
    a8 = x; b8 = y; sel8 = s; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    scramble8();
  endtask

  // Waits for done (bounded), checks latency from the current point, result and flags.
  task automatic finish8(input string tag, input logic [8:0] exp, input int lat);
    int n = 0;
    check({tag, "_busy"}, busy8, 1);
    while (!done8 && n < 40) begin
      check({tag, "_hold"}, {cout8, sum8}, {last_cout, last_sum});
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_sum"}, sum8, exp[7:0]);
    check({tag, "_cout"}, cout8, exp[8]);
    check({tag, "_busy_done"}, busy8, 0);
    last_sum  = exp[7:0];
    last_cout = exp[8];
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic s, input logic c);
    launch8(x, y, s, c);
    finish8(tag, ref8(x, y, s, c), 8);
    tick();
    check({tag, "_done_pulse"}, done8, 0);
  endtask

  initial begin
    logic [7:0] x, y;
    logic       s, c;
    logic [1:0] e1;
    int         n;
    bit         saw_done;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; sel8 = 1'b0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; sel1 = 1'b0; cin1 = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out8", {busy8, done8, cout8, sum8}, 0);
    check("rst_out1", {busy1, done1, cout1, sum1}, 0);
    tick();
    check("idle8", {busy8, done8}, 0);

    // Directed add/sub corners.
    op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b0, 1'b1);
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0);
    op8("sub_10_01_b", 8'h10, 8'h01, 1'b1, 1'b1);
    op8("sub_00_00_b", 8'h00, 8'h00, 1'b1, 1'b1);

    // Start during RUN is ignored; the original result lands on time.
    launch8(8'h12, 8'h34, 1'b0, 1'b1);
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; sel8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    finish8("ignore_start", ref8(8'h12, 8'h34, 1'b0, 1'b1), 5);
    tick();

    // Start held through DONE: second op accepted back-to-back.
    a8 = 8'hC3; b8 = 8'h5A; sel8 = 1'b1; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h7E; b8 = 8'h81; sel8 = 1'b0; cin8 = 1'b1;
    finish8("b2b_first", ref8(8'hC3, 8'h5A, 1'b1, 1'b0), 8);
    tick();
    start8 = 1'b0;
    scramble8();
    check("b2b_restart", {busy8, done8}, 2'b10);
    finish8("b2b_second", ref8(8'h7E, 8'h81, 1'b0, 1'b1), 8);
    tick();

    // Reset mid-RUN aborts without a done pulse.
    launch8(8'h99, 8'h66, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outs", {busy8, done8, cout8, sum8}, 0);
    last_sum = '0; last_cout = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) saw_done = 1'b1;
      tick();
    end
    check("abort_quiet", saw_done, 0);
    op8("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
      if (i % 7 == 0) x = 8'hFF;
      if (i % 5 == 0) y = 8'h00;
      op8($sformatf("rnd%0d", i), x, y, s, c);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end

    // WIDTH=1: exhaustive truth-table sweep, one-cycle RUN.
    for (int k = 0; k < 16; k++) begin
      a1 = k[3]; b1 = k[2]; cin1 = k[1]; sel1 = k[0]; start1 = 1'b1;
      e1 = ref1(k[3], k[2], k[0], k[1]);
      tick();
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      n = 0;
      while (!done1 && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("w1_lat%0d", k), n, 1);
      check($sformatf("w1_res%0d", k), {cout1, sum1}, e1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
